pcm_capture_writer: RTL and testbench

- Captures a 16-bit PCM sample stream (microphone/ADC front end) through a valid/ready handshake.
- Packs two consecutive samples into one 32-bit word and writes the word to memory over the shared DMA port, from startaddr to stopaddr inclusive.
- Raises a one-cycle irq when the buffer is full or when stop has been honoured.
- It is the write-side counterpart of the PWM playback loader: buffers it fills can be replayed by the loader unchanged.

---
 rtl/pcm_capture_writer_pkg.sv | 24 ++
 rtl/pcm_sample_packer.sv | 42 ++++
 rtl/pcm_capture_writer.sv | 149 ++++++++++++++
 tb/tb_pcm_capture_writer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_capture_writer_pkg.sv
// Shared types and constants for the PCM capture writer and the PWM playback loader.
package pcm_capture_writer_pkg;

   localparam int unsigned SAMPLE_W   = 16;
   localparam int unsigned DMA_DATA_W = 32;
   localparam int unsigned ADDR_STEP  = 4;

   typedef enum logic [2:0] {
      IDLE,
      GET_LO,
      GET_HI,
      WRITE,
      WAIT,
      NEXT,
      DONE
   } cap_state_t;

   // One DMA data word: the later sample sits in the upper half-word
   typedef struct packed {
      logic [SAMPLE_W-1:0] hi;
      logic [SAMPLE_W-1:0] lo;
   } pcm_word_t;

endpackage

// File: rtl/pcm_sample_packer.sv
// Collects two accepted samples into one word; pads the upper half when a stop leaves an odd sample.
module pcm_sample_packer
   import pcm_capture_writer_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] PAD_SAMPLE = 16'h0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                sample_valid,
   input  logic                sample_rdy,
   input  logic                hi_phase,
   input  logic                stop_seen,
   input  logic                word_taken,
   output pcm_word_t           word,
   output logic                word_valid
);

   logic accept_c;

   assign accept_c = sample_valid && sample_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         if (word_taken) begin
            word_valid <= 1'b0;
         end
         if (accept_c && !hi_phase) begin
            word.lo <= sample;
         end
         // A real sample always wins over padding, even when stop arrives together with it
         if (hi_phase && sample_rdy && (sample_valid || stop_seen)) begin
            word.hi    <= sample_valid ? sample : PAD_SAMPLE;
            word_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcm_capture_writer.sv
// Captures 16-bit PCM samples, packs pairs into 32-bit words and writes them over the DMA port.
module pcm_capture_writer
   import pcm_capture_writer_pkg::*;
#(
   parameter int unsigned         ADDR_W     = 32,
   parameter logic [SAMPLE_W-1:0] PAD_SAMPLE = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [ADDR_W-1:0]     startaddr,
   input  logic [ADDR_W-1:0]     stopaddr,
   input  logic [SAMPLE_W-1:0]   sample,
   input  logic                  sample_valid,
   output logic                  sample_rdy,
   output logic [ADDR_W-1:0]     dma_addr,
   output logic                  dma_read,
   output logic                  dma_write,
   output logic [DMA_DATA_W-1:0] dma_writedata,
   input  logic                  dma_rdy,
   output logic                  busy,
   output logic                  irq
);

   cap_state_t        state, state_nxt;
   logic              b_start, b_stop;
   logic [ADDR_W-1:0] b_startaddr, b_stopaddr;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic              stopped, stopped_nxt;
   logic              stop_seen_c;
   logic              accept_c;
   logic              write_nxt, irq_nxt, rdy_nxt, busy_nxt;
   pcm_word_t         word;
   logic              word_valid;

   assign dma_read    = 1'b0;
   assign stop_seen_c = b_stop || stopped;
   assign accept_c    = sample_valid && sample_rdy;

   // Input register stage: all control decisions use these copies
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b_start     <= 1'b0;
         b_stop      <= 1'b0;
         b_startaddr <= '0;
         b_stopaddr  <= '0;
      end else begin
         b_start     <= start;
         b_stop      <= stop;
         b_startaddr <= startaddr;
         b_stopaddr  <= stopaddr;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      stopped_nxt = stopped;
      write_nxt   = 1'b0;
      irq_nxt     = 1'b0;
      if (state != IDLE && b_stop) begin
         stopped_nxt = 1'b1;
      end
      unique case (state)
         IDLE: begin
            if (b_start) begin
               addr_nxt    = b_startaddr;
               stopped_nxt = 1'b0;
               state_nxt   = GET_LO;
            end
         end
         GET_LO: begin
            if (accept_c) begin
               state_nxt = GET_HI;
            end else if (stop_seen_c) begin
               state_nxt = DONE;
            end
         end
         GET_HI: begin
            if (accept_c || stop_seen_c) begin
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            write_nxt = word_valid;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (dma_rdy) begin
               state_nxt = NEXT;
            end
         end
         NEXT: begin
            addr_nxt  = addr + ADDR_W'(ADDR_STEP);
            state_nxt = (addr == b_stopaddr || stop_seen_c) ? DONE : GET_LO;
         end
         DONE: begin
            irq_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      rdy_nxt  = (state_nxt == GET_LO) || (state_nxt == GET_HI);
      busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         addr          <= '0;
         stopped       <= 1'b0;
         sample_rdy    <= 1'b0;
         busy          <= 1'b0;
         dma_write     <= 1'b0;
         dma_addr      <= '0;
         dma_writedata <= '0;
         irq           <= 1'b0;
      end else begin
         state      <= state_nxt;
         addr       <= addr_nxt;
         stopped    <= stopped_nxt;
         sample_rdy <= rdy_nxt;
         busy       <= busy_nxt;
         dma_write  <= write_nxt;
         irq        <= irq_nxt;
         if (state == WRITE) begin
            dma_addr      <= addr;
            dma_writedata <= word;
         end
      end
   end

   pcm_sample_packer #(
      .PAD_SAMPLE(PAD_SAMPLE)
   ) u_packer (
      .clk         (clk),
      .rst         (rst),
      .sample      (sample),
      .sample_valid(sample_valid),
      .sample_rdy  (sample_rdy),
      .hi_phase    (state == GET_HI),
      .stop_seen   (stop_seen_c),
      .word_taken  (state == WRITE),
      .word        (word),
      .word_valid  (word_valid)
   );

endmodule

// File: tb/tb_pcm_capture_writer.sv
// Randomized bench for pcm_capture_writer with a transaction-level word/address model.
module tb_pcm_capture_writer;

   localparam logic [15:0] PAD = 16'h0000;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, stop = 1'b0;
   logic [31:0] startaddr = '0, stopaddr = '0;
   logic [15:0] sample = '0;
   logic        sample_valid = 1'b0;
   logic        sample_rdy;
   logic [31:0] dma_addr;
   logic        dma_read, dma_write;
   logic [31:0] dma_writedata;
   logic        dma_rdy = 1'b0;
   logic        busy, irq;

   int n_pass = 0, n_chk = 0;

   // Model state: accepted-but-unpaired samples, expected writes, observed writes
   logic [15:0] pend[$];
   wr_t         exp_q[$];
   wr_t         log_q[$];
   logic [31:0] exp_addr = '0;
   bit          outstanding = 0;
   int          rdy_cnt = 0;
   int          lat_mode = -1;
   int          irq_cnt = 0, acc_cnt = 0;

   pcm_capture_writer #(.ADDR_W(32), .PAD_SAMPLE(PAD)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .startaddr(startaddr), .stopaddr(stopaddr),
      .sample(sample), .sample_valid(sample_valid), .sample_rdy(sample_rdy),
      .dma_addr(dma_addr), .dma_read(dma_read), .dma_write(dma_write),
      .dma_writedata(dma_writedata), .dma_rdy(dma_rdy),
      .busy(busy), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] samp(input int mode, input int idx);
      case (mode)
         0:       return 16'(idx + 1);
         1:       return 16'(32'h1111 * (idx + 1));
         2:       return 16'hAAAA;
         default: return 16'($urandom);
      endcase
   endfunction

   // Compare process and DMA responder; everything sampled mid-cycle
   always @(negedge clk) begin : mon
      wr_t w;
      if (!rst) begin
         pend.delete();
         exp_q.delete();
         outstanding = 0;
         dma_rdy = 1'b0;
      end else begin
         check("dma_read", dma_read, 0);
         if (outstanding) check("rdy_in_wait", sample_rdy, 0);
         if (!busy) check("rdy_idle", sample_rdy, 0);
         if (sample_valid && sample_rdy) begin
            acc_cnt++;
            pend.push_back(sample);
            if (pend.size() == 2) begin
               exp_q.push_back({exp_addr, pend[1], pend[0]});
               exp_addr += 32'd4;
               pend.delete();
            end
         end
         if (dma_write) begin
            check("write_overlap", outstanding, 0);
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("wr_addr", dma_addr, w.a);
               check("wr_data", dma_writedata, w.d);
            end
            log_q.push_back({dma_addr, dma_writedata});
            outstanding = 1;
            rdy_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
         end
         dma_rdy = 1'b0;
         if (outstanding) begin
            if (rdy_cnt == 0) begin
               dma_rdy = 1'b1;
               outstanding = 0;
            end else begin
               rdy_cnt--;
            end
         end
         if (irq) irq_cnt++;
      end
   end

   task automatic run(input logic [31:0] sa, input logic [31:0] ea, input int stop_after,
                      input int mode, input int lat, input int restart_at, input int exp_words);
      int base_irq, base_acc, cyc;
      bit stop_done, finished, saw_busy;
      stop_done = 0; finished = 0; saw_busy = 0; cyc = 0;
      lat_mode = lat;
      log_q.delete();
      exp_addr = sa;
      @(posedge clk); #1;
      startaddr = sa; stopaddr = ea; start = 1'b1;
      base_irq = irq_cnt; base_acc = acc_cnt;
      @(posedge clk); #1;
      start = 1'b0;
      while (!finished && cyc < 2000) begin
         if (busy) saw_busy = 1;
         if (irq_cnt > base_irq) begin
            finished = 1;
         end else begin
            if (stop_after >= 0 && acc_cnt - base_acc >= stop_after) begin
               sample_valid = 1'b0;
               if (!stop_done) begin
                  stop = 1'b1;
                  stop_done = 1;
                  if (pend.size() == 1) begin
                     exp_q.push_back({exp_addr, PAD, pend[0]});
                     exp_addr += 32'd4;
                     pend.delete();
                  end
               end
            end else begin
               sample_valid = ($urandom_range(0, 3) != 0);
               sample = samp(mode, acc_cnt - base_acc);
            end
            if (cyc == restart_at) begin
               start = 1'b1;
               startaddr = 32'h500;
            end else if (cyc == restart_at + 1) begin
               start = 1'b0;
               startaddr = sa;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      check("run_timeout", finished, 1);
      sample_valid = 1'b0;
      stop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("saw_busy", saw_busy, 1);
      check("irq_once", irq_cnt - base_irq, 1);
      check("busy_idle", busy, 0);
      check("exp_drained", exp_q.size(), 0);
      check("pend_empty", pend.size(), 0);
      if (exp_words >= 0) check("n_words", log_q.size(), exp_words);
   endtask

   task automatic check_log(input int i, input logic [31:0] a, input logic [31:0] d);
      check("log_present", i < log_q.size(), 1);
      if (i < log_q.size()) begin
         check("lit_addr", log_q[i].a, a);
         check("lit_data", log_q[i].d, d);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base_irq, n, sa, stop_after, expw;
      bit got;
      #12;
      check("rst_sample_rdy", sample_rdy, 0);
      check("rst_dma_write", dma_write, 0);
      check("rst_dma_addr", dma_addr, 0);
      check("rst_dma_data", dma_writedata, 0);
      check("rst_busy", busy, 0);
      check("rst_irq", irq, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single word
      run(32'h100, 32'h100, -1, 1, -1, -1, 1);
      check_log(0, 32'h100, 32'h2222_1111);

      // Three words, slow DMA
      run(32'h200, 32'h208, -1, 0, 3, -1, 3);
      check_log(0, 32'h200, 32'h0002_0001);
      check_log(1, 32'h204, 32'h0004_0003);
      check_log(2, 32'h208, 32'h0006_0005);
      check("model_next_addr", exp_addr, 32'h20C);

      // Odd stop: one real sample then pad
      run(32'h0, 32'hFC, 1, 2, -1, -1, 1);
      check_log(0, 32'h0, 32'h0000_AAAA);

      // Stop before any sample
      run(32'h80, 32'hFC, 0, 3, -1, -1, 0);

      // Wrap with an ignored second start
      run(32'hFFFF_FFFC, 32'h0, -1, 3, -1, 3, 2);
      check_log(0, 32'hFFFF_FFFC, log_q.size() > 0 ? log_q[0].d : 32'h0);
      check_log(1, 32'h0, log_q.size() > 1 ? log_q[1].d : 32'h0);

      // Asynchronous reset while a write is outstanding
      lat_mode = 30;
      exp_addr = 32'h300;
      startaddr = 32'h300; stopaddr = 32'h310;
      sample = 16'h5A5A; sample_valid = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (dma_write) got = 1;
      end
      check("rst_wait_write", got, 1);
      #1 rst = 1'b0;
      base_irq = irq_cnt;
      #1;
      check("arst_dma_write", dma_write, 0);
      check("arst_sample_rdy", sample_rdy, 0);
      check("arst_busy", busy, 0);
      check("arst_irq", irq, 0);
      sample_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("arst_no_irq", irq_cnt - base_irq, 0);
      check("arst_idle", busy, 0);
      run(32'h40, 32'h40, -1, 1, -1, -1, 1);
      check_log(0, 32'h40, 32'h2222_1111);

      // Randomized ranges, latencies and stop points
      for (int r = 0; r < 10; r++) begin
         n = int'($urandom_range(1, 5));
         sa = int'($urandom & 32'hFFFF_FFFC);
         stop_after = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 2 * n + 1)) : -1;
         if (stop_after < 0 || stop_after >= 2 * n) expw = n;
         else expw = (stop_after + 1) / 2;
         run(32'(sa), 32'(sa) + 32'(4 * (n - 1)), stop_after, 3, -1, -1, expw);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
